pa_ifu_bht_ctrl: RTL



---
 rtl/pa_ifu_bht_pkg.sv | 27 ++
 rtl/pa_ifu_bht_ctrl_if.sv | 43 ++++
 rtl/pa_ifu_bht_upd_buf.sv | 62 ++++++
 rtl/pa_ifu_bht_ctrl.sv | 122 ++++++++++++
 4 files changed

// File: rtl/pa_ifu_bht_pkg.sv
// Shared constants, types and the 2-bit saturating counter update for the BHT controller.
package pa_ifu_bht_pkg;

    localparam int         IDX_W     = 9;
    localparam int         DEPTH     = 1 << IDX_W;
    localparam int         UPD_DEPTH = 2;
    localparam logic [1:0] INIT_CNT  = 2'b01;

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } bht_state_e;

    typedef struct packed {
        logic [IDX_W-1:0] idx;
        logic [2:0]       sel;
        logic [1:0]       cnt;
    } bht_upd_t;

    function automatic logic [1:0] bht_sat_cnt(input logic [1:0] cnt, input logic taken);
        if (taken)
            return (cnt == 2'b11) ? 2'b11 : cnt + 2'b01;
        else
            return (cnt == 2'b00) ? 2'b00 : cnt - 2'b01;
    endfunction

endpackage

// File: rtl/pa_ifu_bht_ctrl_if.sv
// Bundles the CP0, IFU read, IU update and array-port signals of the BHT controller.
interface pa_ifu_bht_ctrl_if;
    import pa_ifu_bht_pkg::*;

    logic             cp0_ifu_bht_en;
    logic             cp0_ifu_bht_inv;
    logic             bht_cp0_inv_done;
    logic             ifu_bht_rd_req;
    logic [IDX_W-1:0] ifu_bht_rd_idx;
    logic             bht_ifu_rd_gnt;
    logic             bht_ifu_pred_vld;
    logic [15:0]      bht_ifu_pred_data;
    logic             iu_bht_upd_vld;
    logic [IDX_W-1:0] iu_bht_upd_idx;
    logic [2:0]       iu_bht_upd_sel;
    logic [1:0]       iu_bht_upd_cnt;
    logic             iu_bht_upd_taken;
    logic             bht_iu_upd_rdy;
    logic             bht_cen;
    logic [IDX_W-1:0] bht_idx;
    logic [15:0]      bht_din;
    logic [15:0]      bht_wen;
    logic [15:0]      bht_dout;

    // Controller side.
    modport slave (
        input  cp0_ifu_bht_en, cp0_ifu_bht_inv, ifu_bht_rd_req, ifu_bht_rd_idx,
               iu_bht_upd_vld, iu_bht_upd_idx, iu_bht_upd_sel, iu_bht_upd_cnt,
               iu_bht_upd_taken, bht_dout,
        output bht_cp0_inv_done, bht_ifu_rd_gnt, bht_ifu_pred_vld, bht_ifu_pred_data,
               bht_iu_upd_rdy, bht_cen, bht_idx, bht_din, bht_wen
    );

    // Requesters plus the array.
    modport master (
        output cp0_ifu_bht_en, cp0_ifu_bht_inv, ifu_bht_rd_req, ifu_bht_rd_idx,
               iu_bht_upd_vld, iu_bht_upd_idx, iu_bht_upd_sel, iu_bht_upd_cnt,
               iu_bht_upd_taken, bht_dout,
        input  bht_cp0_inv_done, bht_ifu_rd_gnt, bht_ifu_pred_vld, bht_ifu_pred_data,
               bht_iu_upd_rdy, bht_cen, bht_idx, bht_din, bht_wen
    );

endinterface

// File: rtl/pa_ifu_bht_upd_buf.sv
// In-order FIFO of pending counter updates {idx, sel, new_cnt}; flush drops every entry.
module pa_ifu_bht_upd_buf
    import pa_ifu_bht_pkg::*;
#(
    parameter int DEPTH_P = UPD_DEPTH
) (
    input  logic     forever_cpuclk,
    input  logic     cpurst_b,
    input  logic     i_push,
    input  logic     i_pop,
    input  logic     i_flush,
    input  bht_upd_t i_data,
    output bht_upd_t o_head,
    output logic     o_full,
    output logic     o_empty
);

    localparam int PTR_W = (DEPTH_P > 1) ? $clog2(DEPTH_P) : 1;
    localparam int CNT_W = $clog2(DEPTH_P + 1);

    bht_upd_t         r_mem [DEPTH_P];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_push;
    logic             w_pop;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH_P - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign o_full  = (r_count == CNT_W'(DEPTH_P));
    assign o_empty = (r_count == '0);
    assign o_head  = r_mem[r_rd_ptr];
    // A push into a full buffer is legal only alongside a pop.
    assign w_push  = i_push & (~o_full | i_pop);
    assign w_pop   = i_pop & ~o_empty;

    always_ff @(posedge forever_cpuclk) begin
        if (w_push && !i_flush)
            r_mem[r_wr_ptr] <= i_data;
    end

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_pop)
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/pa_ifu_bht_ctrl.sv
// BHT array port owner: init sweep after reset/invalidate, then arbitrates prediction reads
// against buffered counter-update writes, one array access per cycle.
module pa_ifu_bht_ctrl
    import pa_ifu_bht_pkg::*;
(
    input  logic                  forever_cpuclk,
    input  logic                  cpurst_b,
    pa_ifu_bht_ctrl_if.slave      bif
);

    bht_state_e       r_state;
    logic [IDX_W-1:0] r_sweep_cnt;
    logic             r_pred_vld;
    logic             r_inv_done;

    logic             w_run;
    logic             w_rd_req;
    logic             w_rd_gnt;
    logic             w_drain;
    logic             w_upd_rdy;
    logic             w_push;
    logic             w_flush;
    logic             w_full;
    logic             w_empty;
    bht_upd_t         w_head;
    bht_upd_t         w_upd_entry;
    logic             w_cen;
    logic [IDX_W-1:0] w_idx;
    logic [15:0]      w_din;
    logic [15:0]      w_wen;

    assign w_run    = (r_state == ST_RUN);
    assign w_rd_req = bif.ifu_bht_rd_req & bif.cp0_ifu_bht_en;
    assign w_rd_gnt = w_run & w_rd_req & ~w_full;
    // Entries about to be flushed by an invalidate are never written.
    assign w_drain  = w_run & ~w_empty & ~bif.cp0_ifu_bht_inv & (w_full | ~w_rd_req);
    assign w_upd_rdy = w_run & (~bif.cp0_ifu_bht_en | ~w_full | w_drain);
    assign w_push   = bif.iu_bht_upd_vld & w_upd_rdy & bif.cp0_ifu_bht_en;
    assign w_flush  = w_run & bif.cp0_ifu_bht_inv;

    assign w_upd_entry = '{idx: bif.iu_bht_upd_idx,
                           sel: bif.iu_bht_upd_sel,
                           cnt: bht_sat_cnt(bif.iu_bht_upd_cnt, bif.iu_bht_upd_taken)};

    pa_ifu_bht_upd_buf #(.DEPTH_P(UPD_DEPTH)) u_upd_buf (
        .forever_cpuclk (forever_cpuclk),
        .cpurst_b       (cpurst_b),
        .i_push         (w_push),
        .i_pop          (w_drain),
        .i_flush        (w_flush),
        .i_data         (w_upd_entry),
        .o_head         (w_head),
        .o_full         (w_full),
        .o_empty        (w_empty)
    );

    always_comb begin
        w_cen = 1'b0;
        w_idx = '0;
        w_din = '0;
        w_wen = '0;
        if (!cpurst_b) begin
            w_cen = 1'b0;
        end else if (!w_run) begin
            w_cen = 1'b1;
            w_idx = r_sweep_cnt;
            w_din = {8{INIT_CNT}};
            w_wen = 16'hFFFF;
        end else if (w_drain) begin
            w_cen = 1'b1;
            w_idx = w_head.idx;
            w_din = {8{w_head.cnt}};
            w_wen = 16'h0003 << {w_head.sel, 1'b0};
        end else if (w_rd_gnt) begin
            w_cen = 1'b1;
            w_idx = bif.ifu_bht_rd_idx;
        end
    end

    assign bif.bht_cen           = w_cen;
    assign bif.bht_idx           = w_idx;
    assign bif.bht_din           = w_din;
    assign bif.bht_wen           = w_wen;
    assign bif.bht_ifu_rd_gnt    = w_rd_gnt & cpurst_b;
    assign bif.bht_iu_upd_rdy    = w_upd_rdy & cpurst_b;
    assign bif.bht_ifu_pred_vld  = r_pred_vld;
    assign bif.bht_ifu_pred_data = bif.bht_dout;
    assign bif.bht_cp0_inv_done  = r_inv_done;

    always_ff @(posedge forever_cpuclk) begin
        if (!cpurst_b) begin
            r_state     <= ST_INIT;
            r_sweep_cnt <= '0;
            r_pred_vld  <= 1'b0;
            r_inv_done  <= 1'b0;
        end else begin
            r_pred_vld <= w_rd_gnt;
            r_inv_done <= 1'b0;
            case (r_state)
                ST_INIT: begin
                    if (bif.cp0_ifu_bht_inv) begin
                        r_sweep_cnt <= '0;
                    end else begin
                        r_sweep_cnt <= r_sweep_cnt + IDX_W'(1);
                        if (r_sweep_cnt == IDX_W'(DEPTH - 1)) begin
                            r_state    <= ST_RUN;
                            r_inv_done <= 1'b1;
                        end
                    end
                end
                ST_RUN: begin
                    if (bif.cp0_ifu_bht_inv) begin
                        r_state     <= ST_INIT;
                        r_sweep_cnt <= '0;
                    end
                end
                default: r_state <= ST_INIT;
            endcase
        end
    end

endmodule
